fetch_sequencer: RTL and testbench

- Owns the program counter and sequences instruction fetch from the combinational program memory (word-indexed ROM, text segment based at byte address 0x00400000).
- Drives the memory address, captures {pc, instruction} pairs into a 2-entry output queue, and hands them to decode with a valid/ready handshake.
- Handles branch/jump redirects, queue flush, out-of-range and misaligned fetch faults, and a start/idle gate.

---
 rtl/fetch_sequencer.sv | 119 +++++++++++
 tb/tb_fetch_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Program counter and instruction fetch sequencer: reads the text-segment ROM,
// buffers {pc, instruction} pairs in a 2-entry queue and hands them to decode.
module fetch_sequencer #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0] imem_instruction,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instruction,
    output logic [DATA_WIDTH-1:0] out_pc,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] fault_pc,
    output logic [DATA_WIDTH-1:0] retired_count
);

    localparam logic [DATA_WIDTH-1:0] LAST_ADDR = TEXT_BASE + DATA_WIDTH'(4 * (MEMORY_DEPTH - 1));

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] pc, pc_n, fault_pc_n;
    logic [1:0]            count, count_n;
    logic [DATA_WIDTH-1:0] head_pc_p1, head_ins_p1, tail_pc_p1, tail_ins_p1;
    logic                  redirect, pop, push, space;

    function automatic logic legal_fetch(input logic [DATA_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr >= TEXT_BASE) && (addr <= LAST_ADDR);
    endfunction

    always_comb begin
        redirect   = redirect_valid && (state != IDLE);
        pop        = (count != 2'd0) && out_ready && !redirect;
        space      = (count != 2'd2) || pop;
        push       = 1'b0;
        state_n    = state;
        pc_n       = pc;
        fault_pc_n = fault_pc;
        count_n    = count;
        if (redirect) begin
            // Redirect flushes the queue and wins over fetch and delivery alike.
            pc_n    = redirect_target;
            count_n = 2'd0;
            if (redirect_target[1:0] != 2'b00) begin
                state_n    = FAULT;
                fault_pc_n = redirect_target;
            end else begin
                state_n = RUN;
            end
        end else begin
            case (state)
                IDLE:    if (start) state_n = RUN;
                RUN: begin
                    if (!legal_fetch(pc)) begin
                        state_n    = FAULT;
                        fault_pc_n = pc;
                    end else if (space) begin
                        push = 1'b1;
                        pc_n = pc + DATA_WIDTH'(4);
                    end
                end
                FAULT:   state_n = FAULT;
                default: state_n = IDLE;
            endcase
            count_n = count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= TEXT_BASE;
            count         <= 2'd0;
            fault_pc      <= '0;
            retired_count <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            count    <= count_n;
            fault_pc <= fault_pc_n;
            if (pop) retired_count <= retired_count + DATA_WIDTH'(1);
        end
    end

    // Queue stage: head feeds decode directly, tail backs it up when decode stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_pc_p1  <= '0;
            head_ins_p1 <= '0;
        end else if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
            head_pc_p1  <= pc;
            head_ins_p1 <= imem_instruction;
        end else if (pop && (count == 2'd2)) begin
            head_pc_p1  <= tail_pc_p1;
            head_ins_p1 <= tail_ins_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && (((count == 2'd1) && !pop) || ((count == 2'd2) && pop))) begin
            tail_pc_p1  <= pc;
            tail_ins_p1 <= imem_instruction;
        end
    end

    assign imem_address    = pc;
    assign out_valid       = (count != 2'd0);
    assign out_pc          = head_pc_p1;
    assign out_instruction = head_ins_p1;
    assign fault           = (state == FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, corner-case sequences,
// then randomized traffic against a queue-based reference model.
module tb_fetch_sequencer;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 32;

    logic        clk, reset, start, out_ready, redirect_valid;
    logic [31:0] imem_address, imem_instruction, out_instruction, out_pc;
    logic [31:0] redirect_target, fault_pc, retired_count;
    logic        out_valid, fault;

    fetch_sequencer #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .TEXT_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_address(imem_address), .imem_instruction(imem_instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fault(fault), .fault_pc(fault_pc), .retired_count(retired_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a >= BASE && (a - BASE) < 32'(4 * DEPTH)) return 32'h2008_0001 + (a - BASE) / 4;
        return 32'hDEAD_0000 ^ a;
    endfunction

    assign imem_instruction = rom_word(imem_address);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 run, 2 fault; queue of delivered-to-be entries.
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    ent_t        mq[$];
    int          m_mode;
    logic [31:0] m_pc, m_fpc, m_ret;
    bit          mchk = 0;

    function automatic bit fetchable(input logic [31:0] a);
        return (a % 4 == 0) && a >= BASE && (a - BASE) / 4 < DEPTH;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_pc = BASE; m_fpc = 0; m_ret = 0;
    endtask

    task automatic model_step(input logic st, input logic rd, input logic rv, input logic [31:0] tg);
        bit   popped, pushed;
        ent_t e;
        if (m_mode != 0 && rv) begin
            mq.delete();
            m_pc = tg;
            if (tg % 4 != 0) begin m_mode = 2; m_fpc = tg; end
            else m_mode = 1;
        end else begin
            popped = (mq.size() > 0) && rd;
            pushed = 0;
            if (m_mode == 0) begin
                if (st) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!fetchable(m_pc)) begin
                    m_mode = 2; m_fpc = m_pc;
                end else if (mq.size() - (popped ? 1 : 0) < 2) begin
                    pushed = 1; e.pc = m_pc; e.ins = rom_word(m_pc);
                end
            end
            if (popped) begin void'(mq.pop_front()); m_ret = m_ret + 1; end
            if (pushed) begin mq.push_back(e); m_pc = m_pc + 4; end
        end
    endtask

    task automatic model_compare();
        chk("m_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("m_out_pc", out_pc, mq[0].pc);
            chk("m_out_ins", out_instruction, mq[0].ins);
        end
        chk("m_addr", imem_address, m_pc);
        chk("m_fault", 32'(fault), 32'(m_mode == 2));
        chk("m_fault_pc", fault_pc, m_fpc);
        chk("m_retired", retired_count, m_ret);
    endtask

    task automatic cycle(input logic st, input logic rd, input logic rv, input logic [31:0] tg);
        start = st; out_ready = rd; redirect_valid = rv; redirect_target = tg;
        @(posedge clk);
        model_step(st, rd, rv, tg);
        #1;
        if (mchk) model_compare();
    endtask

    // Called one time unit after a rising edge; pulses reset between edges.
    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #2 reset = 1'b0;
    endtask

    typedef struct {
        logic        do_rst, st, rd;
        logic        exp_valid;
        logic [31:0] exp_pc, exp_addr, exp_ret;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic d, input logic v,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] n);
        vec_t x;
        x.do_rst = r; x.st = s; x.rd = d; x.exp_valid = v;
        x.exp_pc = p; x.exp_addr = a; x.exp_ret = n;
        tbl.push_back(x);
    endtask

    initial begin
        logic [31:0] last;
        int          n, deliv;
        reset = 1'b1; start = 0; out_ready = 0; redirect_valid = 0; redirect_target = 0;
        model_reset();
        #12 reset = 1'b0;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_ins", out_instruction, 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_fault_pc", fault_pc, 0);
        chk("rst_retired", retired_count, 0);
        chk("rst_addr", imem_address, BASE);
        @(posedge clk); #1;

        // Streaming with decode always ready
        add(1, 1, 1, 0, 0,            32'h0040_0000, 0);
        add(0, 0, 1, 1, 32'h0040_0000, 32'h0040_0004, 0);
        add(0, 0, 1, 1, 32'h0040_0004, 32'h0040_0008, 1);
        add(0, 0, 1, 1, 32'h0040_0008, 32'h0040_000C, 2);
        add(0, 0, 1, 1, 32'h0040_000C, 32'h0040_0010, 3);
        add(0, 0, 1, 1, 32'h0040_0010, 32'h0040_0014, 4);
        // Decode stalled, queue fills and pc holds, then released
        add(1, 1, 0, 0, 0,            32'h0040_0000, 0);
        add(0, 0, 0, 1, 32'h0040_0000, 32'h0040_0004, 0);
        add(0, 0, 0, 1, 32'h0040_0000, 32'h0040_0008, 0);
        add(0, 0, 0, 1, 32'h0040_0000, 32'h0040_0008, 0);
        add(0, 0, 0, 1, 32'h0040_0000, 32'h0040_0008, 0);
        add(0, 0, 0, 1, 32'h0040_0000, 32'h0040_0008, 0);
        add(0, 0, 1, 1, 32'h0040_0004, 32'h0040_000C, 1);
        add(0, 0, 1, 1, 32'h0040_0008, 32'h0040_0010, 2);
        add(0, 0, 1, 1, 32'h0040_000C, 32'h0040_0014, 3);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].do_rst) do_reset();
            cycle(tbl[i].st, tbl[i].rd, 1'b0, 32'h0);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].exp_pc);
                chk($sformatf("tbl%0d_ins", i), out_instruction, rom_word(tbl[i].exp_pc));
            end
            chk($sformatf("tbl%0d_addr", i), imem_address, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_ret", i), retired_count, tbl[i].exp_ret);
        end

        mchk = 1;
        // Redirect with a full queue while decode is ready
        do_reset();
        cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        chk("full_addr", imem_address, 32'h0040_0008);
        cycle(0, 1, 1, 32'h0040_0040);
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_retired", retired_count, 0);
        chk("flush_addr", imem_address, 32'h0040_0040);
        cycle(0, 1, 0, 0);
        chk("redir_pc", out_pc, 32'h0040_0040);

        // Sequential run off the end of the window
        do_reset();
        cycle(1, 1, 0, 0);
        n = 0; deliv = 0; last = 0;
        while (fault !== 1'b1 && n < 60) begin
            if (out_valid) begin last = out_pc; deliv++; end
            cycle(0, 1, 0, 0);
            n++;
        end
        chk("end_fault", 32'(fault), 1);
        chk("end_fault_pc", fault_pc, 32'h0040_0080);
        chk("end_last_pc", last, 32'h0040_007C);
        chk("end_delivered", 32'(deliv), 32);
        chk("end_retired", retired_count, 32);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0);
            chk("end_no_valid", 32'(out_valid), 0);
        end

        // Fault recovery through redirects
        cycle(0, 1, 1, 32'h0040_0002);
        chk("mis_fault", 32'(fault), 1);
        chk("mis_fault_pc", fault_pc, 32'h0040_0002);
        cycle(0, 1, 1, 32'h0040_0010);
        chk("recover_fault", 32'(fault), 0);
        cycle(0, 1, 0, 0);
        chk("recover_valid", 32'(out_valid), 1);
        chk("recover_pc", out_pc, 32'h0040_0010);

        // Asynchronous reset with two entries queued
        do_reset();
        cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        chk("pre_rst_valid", 32'(out_valid), 1);
        #3 reset = 1'b1;
        model_reset();
        #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_addr", imem_address, BASE);
        #6 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0);
            chk("post_rst_idle_valid", 32'(out_valid), 0);
            chk("post_rst_idle_addr", imem_address, BASE);
        end

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        st, rd, rv;
            logic [31:0] tg;
            if ($urandom_range(0, 499) == 0) do_reset();
            st = ($urandom_range(0, 99) < 5);
            rd = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 99) < 4);
            case ($urandom_range(0, 5))
                0, 1, 2: tg = BASE + 4 * $urandom_range(0, DEPTH - 1);
                3:       tg = BASE + 4 * $urandom_range(DEPTH - 4, DEPTH + 8);
                4:       tg = BASE + $urandom_range(0, 127);
                default: tg = $urandom;
            endcase
            cycle(st, rd, rv, tg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
